// File: rtl/cursor_pkg.sv
// Shared types and constants for the cursor_mover block: FSM states,
// per-axis direction encoding and at_edge bit positions.
package cursor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_e;

  // Two-bit signed direction per axis: -1, 0 or +1
  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_NEG  = 2'sb11;
  localparam dir_t DIR_ZERO = 2'sb00;
  localparam dir_t DIR_POS  = 2'sb01;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_TOP    = 1;
  localparam int EDGE_BOTTOM = 0;

  // Opposing buttons held together cancel to zero
  function automatic dir_t decode_dir(input logic neg, input logic pos);
    dir_t d;
    if (neg && !pos) begin
      d = DIR_NEG;
    end else if (pos && !neg) begin
      d = DIR_POS;
    end else begin
      d = DIR_ZERO;
    end
    return d;
  endfunction

endpackage

// File: rtl/axis_step.sv
// Combinational next-coordinate logic for one axis, with clamp or wrap at
// the inclusive [LO, HI] bounds. Arithmetic is done one bit wider than pos.
module axis_step
  import cursor_pkg::*;
#(
  parameter int W  = 10,
  parameter int LO = 1,
  parameter int HI = 640
) (
  input  logic [W-1:0] pos,
  input  dir_t         dir,
  input  logic [W-1:0] step,
  input  logic         wrap_en,
  output logic [W-1:0] next_pos
);

  logic [W:0] p_s;
  logic [W:0] s_s;
  logic [W:0] lo_s;
  logic [W:0] hi_s;
  logic [W:0] n_s;

  // Land exactly on the edge before jumping across it, so no pixel is skipped
  always_comb begin
    p_s  = {1'b0, pos};
    s_s  = {1'b0, step};
    lo_s = (W+1)'(LO);
    hi_s = (W+1)'(HI);
    n_s  = p_s;
    case (dir)
      DIR_NEG: begin
        if (wrap_en && (p_s == lo_s)) begin
          n_s = hi_s;
        end else if (p_s < (lo_s + s_s)) begin
          n_s = lo_s;
        end else begin
          n_s = p_s - s_s;
        end
      end
      DIR_POS: begin
        if (wrap_en && (p_s == hi_s)) begin
          n_s = lo_s;
        end else if ((p_s + s_s) > hi_s) begin
          n_s = hi_s;
        end else begin
          n_s = p_s + s_s;
        end
      end
      default: begin
        n_s = p_s;
      end
    endcase
    next_pos = n_s[W-1:0];
  end

endmodule

// File: rtl/cursor_mover.sv
// Cursor/sprite position generator: turns held direction buttons into a
// rate-limited, accelerating top-left coordinate with clamp/wrap and load.
module cursor_mover
  import cursor_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int X_MIN      = 1,
  parameter int X_MAX      = 640,
  parameter int Y_MIN      = 1,
  parameter int Y_MAX      = 480,
  parameter int SPR_W      = 1,
  parameter int SPR_H      = 1,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int RATE_DIV   = 833333,
  parameter int HOLD_MOVES = 30,
  parameter int STEP_SLOW  = 1,
  parameter int STEP_FAST  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           wrap_en,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           moved,
  output logic [3:0]     at_edge
);

  localparam int X_LO   = X_MIN;
  localparam int X_HI   = X_MAX - SPR_W + 1;
  localparam int Y_LO   = Y_MIN;
  localparam int Y_HI   = Y_MAX - SPR_H + 1;
  localparam int CNT_W  = $clog2(RATE_DIV);
  localparam int HOLD_W = $clog2(HOLD_MOVES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  dir_t                dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [X_W-1:0]      pos_x_q, pos_x_d;
  logic [Y_W-1:0]      pos_y_q, pos_y_d;
  logic                moved_q, moved_d;

  dir_t                dir_x_s, dir_y_s;
  logic                vec_nz_s, entering_s, fast_step_s, move_s;
  logic [X_W-1:0]      step_x_s, nxt_x_s, ld_x_s;
  logic [Y_W-1:0]      step_y_s, nxt_y_s, ld_y_s;
  logic [HOLD_W-1:0]   hold_inc_s;

  assign dir_x_s    = decode_dir(left, right);
  assign dir_y_s    = decode_dir(up, down);
  assign vec_nz_s   = (dir_x_s != DIR_ZERO) || (dir_y_s != DIR_ZERO);
  assign entering_s = (state_q == IDLE) || (dir_x_s != dir_x_q) || (dir_y_s != dir_y_q);

  // Step size and clamped load coordinates; kept apart from the FSM to avoid a loop through axis_step
  always_comb begin
    fast_step_s = (state_q == FAST) && !entering_s;
    step_x_s    = fast_step_s ? X_W'(STEP_FAST) : X_W'(STEP_SLOW);
    step_y_s    = fast_step_s ? Y_W'(STEP_FAST) : Y_W'(STEP_SLOW);
    ld_x_s      = (load_x < X_W'(X_LO)) ? X_W'(X_LO) :
                  (load_x > X_W'(X_HI)) ? X_W'(X_HI) : load_x;
    ld_y_s      = (load_y < Y_W'(Y_LO)) ? Y_W'(Y_LO) :
                  (load_y > Y_W'(Y_HI)) ? Y_W'(Y_HI) : load_y;
  end

  axis_step #(.W(X_W), .LO(X_LO), .HI(X_HI)) u_axis_x (
    .pos      (pos_x_q),
    .dir      (dir_x_s),
    .step     (step_x_s),
    .wrap_en  (wrap_en),
    .next_pos (nxt_x_s)
  );

  axis_step #(.W(Y_W), .LO(Y_LO), .HI(Y_HI)) u_axis_y (
    .pos      (pos_y_q),
    .dir      (dir_y_s),
    .step     (step_y_s),
    .wrap_en  (wrap_en),
    .next_pos (nxt_y_s)
  );

  // FSM next state, rate/hold counters and position update; load wins over buttons
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    moved_d    = 1'b0;
    move_s     = 1'b0;
    hold_inc_s = (hold_q == HOLD_W'(HOLD_MOVES)) ? hold_q : hold_q + HOLD_W'(1);

    if (load) begin
      pos_x_d = ld_x_s;
      pos_y_d = ld_y_s;
      moved_d = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
      dir_x_d = DIR_ZERO;
      dir_y_d = DIR_ZERO;
    end else if (!vec_nz_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
      dir_x_d = DIR_ZERO;
      dir_y_d = DIR_ZERO;
    end else if (entering_s) begin
      move_s  = 1'b1;
      cnt_d   = '0;
      hold_d  = HOLD_W'(1);
      dir_x_d = dir_x_s;
      dir_y_d = dir_y_s;
      state_d = (HOLD_MOVES <= 1) ? FAST : SLOW;
    end else if (cnt_q == CNT_W'(RATE_DIV - 1)) begin
      move_s  = 1'b1;
      cnt_d   = '0;
      hold_d  = hold_inc_s;
      state_d = (hold_inc_s >= HOLD_W'(HOLD_MOVES)) ? FAST : SLOW;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (move_s) begin
      pos_x_d = nxt_x_s;
      pos_y_d = nxt_y_s;
      moved_d = (nxt_x_s != pos_x_q) || (nxt_y_s != pos_y_q);
    end else begin
      moved_d = moved_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dir_x_q <= DIR_ZERO;
      dir_y_q <= DIR_ZERO;
      pos_x_q <= X_W'(X_INIT);
      pos_y_q <= Y_W'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      moved_q <= moved_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign moved = moved_q;

  assign at_edge[EDGE_LEFT]   = (pos_x_q == X_W'(X_LO));
  assign at_edge[EDGE_RIGHT]  = (pos_x_q == X_W'(X_HI));
  assign at_edge[EDGE_TOP]    = (pos_y_q == Y_W'(Y_LO));
  assign at_edge[EDGE_BOTTOM] = (pos_y_q == Y_W'(Y_HI));

endmodule

// File: doc/cursor_mover.md
# cursor_mover

Parametrised cursor/sprite position generator for the VGA display path. Converts held up/down/left/right buttons into a registered top-left (x, y) screen coordinate. Movement is rate-limited, supports diagonals and accelerates on long holds. Edge behaviour is either clamp or wrap, and a position load port is provided. The block sits between the debounced button inputs and the sprite renderer.

## Interface
- X_W, 10, width of x coordinate
- Y_W, 9, width of y coordinate
- X_MIN / X_MAX, 1 / 640, horizontal screen bounds (inclusive)
- Y_MIN / Y_MAX, 1 / 480, vertical screen bounds (inclusive)
- SPR_W / SPR_H, 1 / 1, sprite size in pixels; legal top-left range is X_LO=X_MIN..X_HI=X_MAX-SPR_W+1 (Y likewise)
- X_INIT / Y_INIT, 320 / 240, reset position (must lie in legal range)
- RATE_DIV, 833333, clk cycles between moves while held (>=2)
- HOLD_MOVES, 30, consecutive moves before switching to fast step
- STEP_SLOW / STEP_FAST, 1 / 4, pixels per move (each < legal span)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- up, down, left, right  in  1 each  debounced level inputs
- wrap_en  in  1  1 = wrap at edges, 0 = clamp
- load  in  1  single-cycle load strobe
- load_x / load_y  in  X_W / Y_W  load coordinates
- pos_x / pos_y  out  X_W / Y_W  registered top-left position
- moved  out  1  registered one-cycle pulse when the position changes or a load occurs
- at_edge  out  4  {left, right, top, bottom}; set when pos equals X_LO, X_HI, Y_LO, Y_HI

## Operation
- Direction decode: up&down cancels vertical; left&right cancels horizontal. Result is a vector dx, dy ∈ {-1,0,+1}. Diagonals are legal.
- States (the shared package enumerates IDLE, SLOW and FAST):
  - IDLE: vector zero. Rate counter held at 0. A nonzero vector causes a move on the next edge and a transition to SLOW with hold=1.
  - SLOW/FAST: the rate counter counts 0..RATE_DIV-1 and a move occurs at wrap.
  - Each move increments hold (saturating). SLOW→FAST when hold reaches HOLD_MOVES.
  - A vector change to a different nonzero value: immediate move, SLOW, hold=1, counter=0.
  - Vector zero: IDLE, counter=0, hold=0.
- Step is STEP_SLOW in SLOW and on the entering move; it is STEP_FAST in FAST.
- Per-axis arithmetic is done in width+1 bits with no overflow:
  - Clamp, decrementing: pos<LO+step gives LO, else pos-step.
  - Clamp, incrementing: pos>HI-step gives HI, else pos+step.
  - Wrap, decrementing: pos==LO gives HI; pos<LO+step gives LO; else pos-step.
  - Wrap, incrementing: symmetric to the decrementing case.
  - Landing on the edge precedes the jump, so no pixels are skipped.
- Load has priority over everything:
  - pos is set to load_x/load_y, each clamped to [LO,HI] regardless of wrap_en.
  - moved=1, state→IDLE, counter=0, hold=0.
  - Directions are ignored that cycle.
- moved asserts only if the value of pos_x or pos_y actually changes, or on a load.

## Timing
- Reset values: pos_x=X_INIT, pos_y=Y_INIT, moved=0, state IDLE, counters 0. at_edge follows the reset pos.
- Latency from press in IDLE to the new pos: 1 clk. Held moves occur every RATE_DIV clks after that.
- Latency from load to pos: 1 clk. moved coincides with the new pos value.
- at_edge is combinational from the registered pos.
- A reset mid-move returns to the reset values immediately (asynchronous). There is no residual tick after reset is released.
- wrap_en and step selection are sampled at the move edge.

## Structure
- Package cursor_pkg: state enum, direction vector encoding (2-bit signed per axis), edge-bit index constants.
- Sub-module axis_step, instantiated for x and y. It is combinational next-coordinate logic, parametrised by width and LO/HI. Inputs are pos, dir, step and wrap_en. Output is the next pos.
- The top level holds the FSM, rate counter ($clog2(RATE_DIV) bits), hold counter and output registers.

## Test plan
Bench parameters: X 1..20, Y 1..10, SPR_W=2, SPR_H=1, RATE_DIV=4, HOLD_MOVES=3, STEP_FAST=4, X_INIT=10, Y_INIT=5.
- Reset → pos=(10,5), moved=0, at_edge=0. Hold right for 13 clks → x=11@c1, 12@c5, 13@c9, then FAST: 17@c13.
- Clamp: x=18 while holding right → 19 (X_HI=19), at_edge[right]=1. Further ticks give no change and moved stays 0.
- Wrap: wrap_en=1, x=19, one right move → x=1. With x=3 in FAST, a left move → x=1, then the next left move → x=19.
- up+left together from (10,5) → (9,4) after 1 clk. up+down+right → (11,5) only.
- load with load=(25,0) while right is held → pos=(19,1), moved=1 for 1 clk, FSM IDLE; a move follows 1 clk later.
- reset asserted mid-hold in FAST → pos=(10,5) asynchronously. Releasing reset with right held → move 1 clk later using STEP_SLOW.
